// File: rtl/reduction_serial_rx_pkg.sv
// rtl/reduction_serial_rx_pkg.sv - shared state encodings, default width and result type
// for the reduction-operator serial link.
package reduction_serial_rx_pkg;

   localparam logic [1:0] RED_ST_IDLE = 2'd0;
   localparam logic [1:0] RED_ST_DATA = 2'd1;
   localparam logic [1:0] RED_ST_PAR  = 2'd2;
   localparam logic [1:0] RED_ST_DONE = 2'd3;

   localparam int RED_W_DEF = 4;

   typedef struct packed {
      logic r_and;
      logic r_or;
      logic r_xor;
      logic r_nand;
      logic r_nor;
   } red_res_t;

endpackage

// File: rtl/reduction_serial_rx_reduce_unit.sv
// rtl/reduction_serial_rx_reduce_unit.sv - combinational AND/OR/XOR/NAND/NOR reduction of
// a W-bit word; also the parity source for the future transmitter.
module red_reduce_unit
   import reduction_serial_rx_pkg::*;
#(
   parameter int W = RED_W_DEF
) (
   input  logic [W-1:0] i_data,
   output red_res_t     o_res
);

   always_comb begin
      o_res        = '0;
      o_res.r_and  = &i_data;
      o_res.r_or   = |i_data;
      o_res.r_xor  = ^i_data;
      o_res.r_nand = ~&i_data;
      o_res.r_nor  = ~|i_data;
   end

endmodule

// File: rtl/reduction_serial_rx.sv
// rtl/reduction_serial_rx.sv - LSB-first W-bit deserialiser with even-parity check and
// registered reduction results. Optional saturating error counter: RED_RX_ERR_CNT_EN.
module reduction_serial_rx
   import reduction_serial_rx_pkg::*;
#(
   parameter int W  = RED_W_DEF,
   parameter int CW = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sof,
   input  logic         in_valid,
   input  logic         in_bit,
   output logic         busy,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         red_and,
   output logic         red_or,
   output logic         red_xor,
   output logic         red_nand,
   output logic         red_nor,
`ifdef RED_RX_ERR_CNT_EN
   output logic [7:0]   err_cnt,
`endif
   output logic         par_err
);

   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_shift;
   red_res_t      w_res;
   logic          w_start;
   logic          w_finish;

   red_reduce_unit #(.W(W)) u_reduce (
      .i_data (r_shift),
      .o_res  (w_res)
   );

   // sof restarts from IDLE, DATA or PAR; in DONE it is dropped.
   assign w_start  = in_valid && sof && (r_state != RED_ST_DONE);
   assign w_finish = in_valid && !sof && (r_state == RED_ST_PAR);
   assign busy     = (r_state != RED_ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RED_ST_IDLE;
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (w_start) begin
         r_state    <= RED_ST_DATA;
         r_cnt      <= CW'(1);
         r_shift[0] <= in_bit;
      end else begin
         case (r_state)
            RED_ST_DATA: begin
               if (in_valid) begin
                  for (int i = 0; i < W; i++) begin
                     if (r_cnt == CW'(i)) r_shift[i] <= in_bit;
                  end
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == CW'(W - 1)) r_state <= RED_ST_PAR;
               end
            end
            RED_ST_PAR: begin
               if (in_valid) r_state <= RED_ST_DONE;
            end
            RED_ST_DONE: begin
               r_state <= RED_ST_IDLE;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= RED_ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Results are captured as the parity bit arrives, so they are valid during DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         red_and   <= 1'b0;
         red_or    <= 1'b0;
         red_xor   <= 1'b0;
         red_nand  <= 1'b0;
         red_nor   <= 1'b0;
         par_err   <= 1'b0;
      end else begin
         out_valid <= w_finish;
         if (w_finish) begin
            out_data <= r_shift;
            red_and  <= w_res.r_and;
            red_or   <= w_res.r_or;
            red_xor  <= w_res.r_xor;
            red_nand <= w_res.r_nand;
            red_nor  <= w_res.r_nor;
            par_err  <= in_bit ^ w_res.r_xor;
         end
      end
   end

`ifdef RED_RX_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (w_finish && (in_bit ^ w_res.r_xor) && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule
